// File: rtl/data_memory_hs_pkg.sv
// Shared types for the handshaked data memory: access sizes, FSM states, lane constants.
// Optional access-fault checking is enabled by defining DATA_MEMORY_HS_ERR_EN.
package data_memory_hs_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALF     = 2'd1,
        SIZE_WORD     = 2'd2,
        SIZE_WORD_ALT = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int CNT_W  = 4;

    // Encoding 3 is an alias for a full-word access.
    function automatic size_e norm_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SIZE_WORD : size_e'(raw);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
// Contents are never reset; read data holds until the next read.
module dmem_array
    import data_memory_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic [IDX_W-1:0]       addr_i,
    input  logic                   we_i,
    input  logic [DATA_W/8-1:0]    be_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic                   re_i,
    output logic [DATA_W-1:0]      rdata_o
);

    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_hs.sv
// Single-outstanding data memory with valid/ready request and response channels.
// Define DATA_MEMORY_HS_ERR_EN to fault misaligned/out-of-range accesses instead of aligning/wrapping.
module data_memory_hs
    import data_memory_hs_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output state_e             dbg_state_o
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with rsp_valid && rsp_ready, and the
    // response payload is held stable from rsp_valid rising until that transfer.

    localparam int NB    = DATA_W / BYTE_W;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI_W  = ADDR_W - OFF_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               ld_q;
    logic               err_q;
    size_e              size_q;
    logic [OFF_W-1:0]   lane_q;
    logic               sgn_q;

    logic               accept;
    size_e              size_d;
    logic [OFF_W-1:0]   lane_raw;
    logic [OFF_W-1:0]   lane_d;
    logic [IDX_W-1:0]   idx_d;
    logic               mis_d;
    logic               err_d;
    logic [NB-1:0]      be_d;
    logic [DATA_W-1:0]  wdata_d;
    logic               wr_en;
    logic               rd_en;
    logic [DATA_W-1:0]  arr_rdata;

    assign accept = req_valid & req_ready_q;

    // Request decode: lane selection, byte enables and write-data replication.
    always_comb begin
        size_d   = norm_size(req_size);
        lane_raw = req_addr[OFF_W-1:0];
        idx_d    = req_addr[OFF_W +: IDX_W];
        mis_d    = 1'b0;
        lane_d   = lane_raw;
        be_d     = '1;
        wdata_d  = req_wdata;
        case (size_d)
            SIZE_BYTE: begin
                be_d    = NB'(1) << lane_raw;
                wdata_d = {NB{req_wdata[BYTE_W-1:0]}};
            end
            SIZE_HALF: begin
                mis_d   = lane_raw[0];
                lane_d  = {lane_raw[OFF_W-1:1], 1'b0};
                be_d    = NB'(3) << lane_d;
                wdata_d = {(NB/2){req_wdata[HALF_W-1:0]}};
            end
            default: begin
                mis_d  = |lane_raw;
                lane_d = '0;
            end
        endcase
    end

`ifdef DATA_MEMORY_HS_ERR_EN
    logic oob_d;
    assign oob_d = req_addr[ADDR_W-1:OFF_W] >= HI_W'(DEPTH);
    assign err_d = mis_d | oob_d;
`else
    // Without fault checking the index simply wraps, so the upper address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mis_d, req_addr[ADDR_W-1:OFF_W+IDX_W]};
    assign err_d = 1'b0;
`endif

    assign wr_en = accept & req_we & ~err_d;
    assign rd_en = accept & ~req_we;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .addr_i  (idx_d),
        .we_i    (wr_en),
        .be_i    (be_d),
        .wdata_i (wdata_d),
        .re_i    (rd_en),
        .rdata_o (arr_rdata)
    );

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            ld_q        <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= SIZE_WORD;
            lane_q      <= '0;
            sgn_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        ld_q        <= ~req_we;
                        err_q       <= err_d;
                        size_q      <= size_d;
                        lane_q      <= lane_d;
                        sgn_q       <= req_signed;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == LAST_CNT) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // Leaving RESP re-opens the request port one cycle later, never in this cycle.
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] fmt;
    logic              ext;

    // Load formatting from the held array output and the captured request attributes.
    always_comb begin
        shifted = arr_rdata >> {lane_q, 3'b000};
        ext     = 1'b0;
        fmt     = arr_rdata;
        case (size_q)
            SIZE_BYTE: begin
                ext = sgn_q & shifted[BYTE_W-1];
                fmt = {{(DATA_W-BYTE_W){ext}}, shifted[BYTE_W-1:0]};
            end
            SIZE_HALF: begin
                ext = sgn_q & shifted[HALF_W-1];
                fmt = {{(DATA_W-HALF_W){ext}}, shifted[HALF_W-1:0]};
            end
            default: fmt = arr_rdata;
        endcase
    end

    assign rsp_rdata   = (rsp_valid_q & ld_q & ~err_q) ? fmt : '0;
`ifdef DATA_MEMORY_HS_ERR_EN
    assign rsp_err     = rsp_valid_q & err_q;
`else
    assign rsp_err     = 1'b0;
`endif
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs at default parameters; expectations follow DATA_MEMORY_HS_ERR_EN.
module tb_data_memory_hs;
    import data_memory_hs_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 32;
    localparam int LATENCY = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    state_e            dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    data_memory_hs #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        else pass_cnt++;
    endtask

    // One full request/response; hold keeps rsp_ready low for that many RESP cycles.
    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int n;
        int lat;
        logic [31:0] exp_d;
        @(negedge clock);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({name, ".req_ready"}, 32'(req_ready), 32'd1);
        exp_q.push_back(exp_rdata);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'(LATENCY));
        exp_d = exp_q.pop_front();
        check({name, ".rdata"}, rsp_rdata, exp_d);
        check({name, ".err"}, 32'(rsp_err), 32'(exp_err));
        check({name, ".busy"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({name, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, ".hold_rdata"}, rsp_rdata, exp_d);
            check({name, ".hold_busy"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check({name, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({name, ".reopen"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset state
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check("rst.err", 32'(rsp_err), 32'd0);
        check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clock);
        check("post_rst.req_ready", 32'(req_ready), 32'd1);

        // Word store/load, byte store with signed/unsigned byte loads
        txn("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_w10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 0);
        txn("st_b13", 1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_bs13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 0);
        txn("ld_bu13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 32'h00000080, 1'b0, 0);
        // Response held off for 5 cycles
        txn("ld_w10_hold", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h80ADBEEF, 1'b0, 5);

        // Misaligned half load
`ifdef DATA_MEMORY_HS_ERR_EN
        txn("ld_h11", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1, 0);
`else
        txn("ld_h11", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 32'h0000BEEF, 1'b0, 0);
`endif
        txn("ld_hs12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 32'hFFFF80AD, 1'b0, 0);
        txn("ld_sz3", 1'b0, 32'h10, 32'h0, 2'd3, 1'b1, 32'h80ADBEEF, 1'b0, 0);

        // Reset during WAIT after an accepted store
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_size  = 2'd2;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rst_wait.req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rst_wait.in_wait", 32'(dbg_state), 32'(ST_WAIT));
        reset = 1'b1;
        @(negedge clock);
        check("rst_wait.req_ready_rst", 32'(req_ready), 32'd0);
        check("rst_wait.state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst_wait.no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn("ld_w20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b0, 0);

        // Half store and mixed-size reads
        txn("st_h22", 1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_bu21", 1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 32'h00000056, 1'b0, 0);
        txn("ld_w20b", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'hABCD5678, 1'b0, 0);

        // Out-of-range word store: faulted, or wrapped onto word 0
        txn("st_w0", 1'b1, 32'h0, 32'h11111111, 2'd2, 1'b0, 32'h0, 1'b0, 0);
`ifdef DATA_MEMORY_HS_ERR_EN
        txn("st_w400", 1'b1, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b1, 0);
        txn("ld_w0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'h11111111, 1'b0, 0);
`else
        txn("st_w400", 1'b1, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_w0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/data_memory_hs.md
DATA_MEMORY_HS -- requirements
Module: data_memory_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, number of words stored.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal 1..8).
REQ-005 SHALL have port clock, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have ports req_valid input 1 and req_ready output 1: request handshake.
REQ-008 SHALL have ports req_we input 1 (1=store) and req_addr input ADDR_W (byte address).
REQ-009 SHALL have ports req_wdata input DATA_W, req_size input 2 (0=byte, 1=half, 2=word), and req_signed input 1 (sign-extend loads).
REQ-010 SHALL have ports rsp_valid output 1 and rsp_ready input 1: response handshake.
REQ-011 SHALL have ports rsp_rdata output DATA_W (load data, 0 for stores) and rsp_err output 1 (access fault).

Function
REQ-012 SHALL run a 3-state FSM: IDLE -> WAIT on accept; WAIT -> RESP when the latency counter reaches LATENCY-1; RESP -> IDLE when rsp_ready=1.
REQ-013 SHALL drive req_ready=1 only in IDLE; one outstanding request; no accept in the RESP-exit cycle.
REQ-014 SHALL assert rsp_valid exactly LATENCY cycles after the accepting edge and hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready=1.
REQ-015 SHALL, with LATENCY=1, skip WAIT (IDLE -> RESP directly).
REQ-016 SHALL select word index req_addr[log2(DATA_W/8)+:log2(DEPTH)] and byte lane from the low address bits.
REQ-017 SHALL commit stores at the accepting edge, writing only the lanes selected by req_size/lane (byte, half, or full word).
REQ-018 SHALL capture load data at the accepting edge; loads return the addressed byte/half right-aligned, sign-extended if req_signed=1, else zero-extended.
REQ-019 SHALL treat req_size=3 as word.
REQ-020 SHALL handle back-to-back traffic at one request per LATENCY+1 cycles when rsp_ready is held at 1.

Reset
REQ-021 SHALL, on reset, force state IDLE, clear the counter, and drive req_ready=0 in the reset cycle, then 1 afterwards; rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-022 SHALL, on reset mid-operation, discard the pending response; a store already accepted remains committed; memory contents are never cleared by reset.

Configuration
REQ-023 SHALL, with macro DATA_MEMORY_HS_ERR_EN defined, flag misaligned addresses (half with addr[0]=1, word with nonzero lane bits) or word index >= DEPTH as rsp_err=1, suppress the store, and return rsp_rdata=0, with normal latency.
REQ-024 SHALL, without DATA_MEMORY_HS_ERR_EN, tie rsp_err=0, force-align addresses by clearing offending low bits, and wrap the word index modulo DEPTH.

Structure
REQ-025 SHALL place the access-size encoding, the FSM state enum, and lane/size helper constants in shared package data_memory_hs_pkg.
REQ-026 SHALL instantiate one sub-module dmem_array: DEPTH x DATA_W storage with per-byte write enables and synchronous read.

Verification
REQ-027 SHALL cover: reset, then store word 0xDEADBEEF at 0x10, then load word at 0x10 with LATENCY=2 -> rsp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-028 SHALL cover: store byte 0x80 to 0x13, then signed load byte at 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word at 0x10 -> 0x80ADBEEF.
REQ-029 SHALL cover: half load at 0x11 with ERR_EN -> err=1, rdata=0; without ERR_EN -> data of half at 0x10, err=0.
REQ-030 SHALL cover: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rdata stable, req_ready=0 throughout; accept resumes the cycle after the rsp handshake.
REQ-031 SHALL cover: assert reset in the WAIT cycle after a word store of 0x12345678 to 0x20 -> no rsp_valid; a subsequent load at 0x20 returns 0x12345678.
REQ-032 SHALL cover: word store to byte address 4*DEPTH (=0x400 at default) with ERR_EN -> err=1, and word 0 is unchanged.
